countdown_timer_27: RTL and testbench

- Programmable 27-bit down-counter with prescaler, load handshake, and one-shot/periodic modes.
- Sits directly upstream of the 27-bit capture register (gen_reg_27): cap_d drives its d, cap_en drives its en.
- Used as the final-project timer peripheral; the CPU reads the captured snapshot from the register.

---
 rtl/countdown_timer_27_pkg.sv | 13 +
 rtl/countdown_timer_27_prescaler.sv | 28 ++
 rtl/countdown_timer_27.sv | 112 +++++++++++
 tb/tb_countdown_timer_27.sv | 299 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_timer_27_pkg.sv
// Shared definitions for the countdown timer: state encoding and default widths.
package countdown_timer_27_pkg;

    localparam int TIMER_WIDTH = 27;
    localparam int TIMER_PW    = 8;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_RUN     = 2'd1,
        S_EXPIRED = 2'd2
    } state_t;

endpackage

// File: rtl/countdown_timer_27_prescaler.sv
// Prescaler: o_tick fires combinationally when enabled and pcnt is 0; pcnt then reloads.
// Restart takes priority over enable; no backpressure.
module timer_prescaler #(
    parameter int PW = 8
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic [PW-1:0] i_reload,
    input  logic          i_restart,
    input  logic          i_enable,
    output logic          o_tick
);

    logic [PW-1:0] r_pcnt;

    assign o_tick = i_enable && (r_pcnt == '0);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_pcnt <= '0;
        end else if (i_restart) begin
            r_pcnt <= i_reload;
        end else if (i_enable) begin
            r_pcnt <= (r_pcnt == '0) ? i_reload : r_pcnt - PW'(1);
        end
    end

endmodule

// File: rtl/countdown_timer_27.sv
// 27-bit prescaled down-counter with load handshake and one-shot/periodic modes.
// Load accepted only in IDLE (load_ready); expired/cap_en pulse one cycle after the final tick.
module countdown_timer_27
    import countdown_timer_27_pkg::*;
#(
    parameter int WIDTH = TIMER_WIDTH,
    parameter int PW    = TIMER_PW
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_value,
    input  logic [PW-1:0]    prescale,
    input  logic             periodic,
    input  logic             start,
    input  logic             stop,
    output logic [WIDTH-1:0] count,
    output logic             busy,
    output logic             expired,
    output logic [WIDTH-1:0] cap_d,
    output logic             cap_en
);

    state_t           r_state;
    logic [WIDTH-1:0] r_count;
    logic [WIDTH-1:0] r_reload;
    logic [PW-1:0]    r_pscale;
    logic             r_periodic;
    logic             r_stop_ack;

    logic w_load_fire;
    logic w_start_ok;
    logic w_reload_run;
    logic w_enable;
    logic w_tick;
    logic w_last;

    assign load_ready   = (r_state == S_IDLE);
    assign w_load_fire  = load_valid && load_ready;
    // A same-cycle load wins; start must be re-asserted afterwards.
    assign w_start_ok   = (r_state == S_IDLE) && !w_load_fire && start && !stop
                          && (r_reload != '0);
    assign w_reload_run = (r_state == S_EXPIRED) && !stop && r_periodic;
    assign w_enable     = (r_state == S_RUN) && !stop;
    assign w_last       = (r_count <= WIDTH'(1));

    timer_prescaler #(.PW(PW)) u_prescaler (
        .clk       (clk),
        .clr_n     (clr_n),
        .i_reload  (r_pscale),
        .i_restart (w_start_ok || w_reload_run),
        .i_enable  (w_enable),
        .o_tick    (w_tick)
    );

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state    <= S_IDLE;
            r_count    <= '0;
            r_reload   <= '0;
            r_pscale   <= '0;
            r_periodic <= 1'b0;
            r_stop_ack <= 1'b0;
        end else begin
            r_stop_ack <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_load_fire) begin
                        r_reload   <= load_value;
                        r_count    <= load_value;
                        r_pscale   <= prescale;
                        r_periodic <= periodic;
                    end else if (w_start_ok) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (stop) begin
                        r_state    <= S_IDLE;
                        r_stop_ack <= 1'b1;
                    end else if (w_tick) begin
                        // Saturate: a restart from count 0 expires on its first tick.
                        r_count <= (r_count == '0) ? '0 : r_count - WIDTH'(1);
                        if (w_last) begin
                            r_state <= S_EXPIRED;
                        end
                    end
                end
                S_EXPIRED: begin
                    if (stop) begin
                        r_state <= S_IDLE;
                    end else if (r_periodic) begin
                        r_count <= r_reload;
                        r_state <= S_RUN;
                    end else begin
                        r_count <= '0;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign count   = r_count;
    assign busy    = (r_state == S_RUN) || (r_state == S_EXPIRED);
    assign expired = (r_state == S_EXPIRED);
    assign cap_d   = r_count;
    assign cap_en  = expired || r_stop_ack;

endmodule

// File: tb/tb_countdown_timer_27.sv
// Self-checking bench for countdown_timer_27: cap_en events are scoreboarded, state checked inline.
module tb_countdown_timer_27;

    logic        clk = 1'b0;
    logic        clr_n = 1'b1;
    logic        load_valid = 1'b0;
    logic        load_ready;
    logic [26:0] load_value = '0;
    logic [7:0]  prescale = '0;
    logic        periodic = 1'b0;
    logic        start = 1'b0;
    logic        stop = 1'b0;
    logic [26:0] count;
    logic        busy;
    logic        expired;
    logic [26:0] cap_d;
    logic        cap_en;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct packed {
        logic [26:0] d;
        logic        x;
    } ev_t;
    ev_t exp_q[$];

    countdown_timer_27 dut (
        .clk        (clk),
        .clr_n      (clr_n),
        .load_valid (load_valid),
        .load_ready (load_ready),
        .load_value (load_value),
        .prescale   (prescale),
        .periodic   (periodic),
        .start      (start),
        .stop       (stop),
        .count      (count),
        .busy       (busy),
        .expired    (expired),
        .cap_d      (cap_d),
        .cap_en     (cap_en)
    );

    always #5 clk = ~clk;

    // Every cap_en pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        ev_t e;
        if (cap_en) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL cap_event: unexpected cap_en with cap_d=%0d expired=%0b, required no pulse",
                         cap_d, expired);
            end else begin
                e = exp_q.pop_front();
                if (cap_d !== e.d || expired !== e.x) begin
                    n_errors++;
                    $display("FAIL cap_event: cap_d=%0d expired=%0b, required cap_d=%0d expired=%0b",
                             cap_d, expired, e.d, e.x);
                end
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_load(input logic [26:0] v, input logic [7:0] p, input logic per);
        load_value = v;
        prescale   = p;
        periodic   = per;
        load_valid = 1'b1;
        cyc();
        load_valid = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1;
        cyc();
        start = 1'b0;
    endtask

    function automatic logic [26:0] periodic_count(input int k);
        case (k % 5)
            0, 1:    return 27'd2;
            2, 3:    return 27'd1;
            default: return 27'd0;
        endcase
    endfunction

    task automatic test_reset();
        #1 clr_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 27'd0 || load_ready !== 1'b1 || busy !== 1'b0 ||
            expired !== 1'b0 || cap_en !== 1'b0 || cap_d !== 27'd0) begin
            n_errors++;
            $display("FAIL reset: count=%0d ready=%0b busy=%0b expired=%0b cap_en=%0b cap_d=%0d, required 0 1 0 0 0 0",
                     count, load_ready, busy, expired, cap_en, cap_d);
        end
        @(posedge clk);
        #1 clr_n = 1'b1;
        cyc();
    endtask

    task automatic test_one_shot();
        logic [26:0] exp_cnt;
        do_load(27'd3, 8'd0, 1'b0);
        exp_q.push_back('{d: 27'd0, x: 1'b1});
        do_start();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            exp_cnt = (k <= 3) ? 27'(3 - k) : 27'd0;
            n_checks++;
            if (count !== exp_cnt || expired !== (k == 3) || busy !== (k <= 3)) begin
                n_errors++;
                $display("FAIL one_shot k=%0d: count=%0d expired=%0b busy=%0b, required %0d %0b %0b",
                         k, count, expired, busy, exp_cnt, (k == 3), (k <= 3));
            end
        end
    endtask

    task automatic test_periodic();
        do_load(27'd2, 8'd1, 1'b1);
        for (int i = 0; i < 3; i++) exp_q.push_back('{d: 27'd0, x: 1'b1});
        do_start();
        for (int k = 1; k <= 15; k++) begin
            cyc();
            n_checks++;
            if (count !== periodic_count(k) || expired !== ((k % 5) == 4)) begin
                n_errors++;
                $display("FAIL periodic k=%0d: count=%0d expired=%0b, required %0d %0b",
                         k, count, expired, periodic_count(k), ((k % 5) == 4));
            end
        end
        exp_q.push_back('{d: 27'd2, x: 1'b0});
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || count !== 27'd2) begin
            n_errors++;
            $display("FAIL periodic_stop: busy=%0b count=%0d, required 0 2", busy, count);
        end
        cyc();
    endtask

    task automatic test_handshake();
        do_load(27'd3, 8'd0, 1'b1);
        exp_q.push_back('{d: 27'd0, x: 1'b1});
        do_start();
        load_value = 27'd99;
        load_valid = 1'b1;
        for (int k = 1; k <= 2; k++) begin
            cyc();
            n_checks++;
            if (load_ready !== 1'b0 || count !== 27'(3 - k)) begin
                n_errors++;
                $display("FAIL busy_load k=%0d: ready=%0b count=%0d, required 0 %0d",
                         k, load_ready, count, 3 - k);
            end
        end
        load_valid = 1'b0;
        cyc();
        cyc();
        n_checks++;
        if (count !== 27'd3 || busy !== 1'b1) begin
            n_errors++;
            $display("FAIL reload_kept: count=%0d busy=%0b, required 3 1", count, busy);
        end
        exp_q.push_back('{d: 27'd3, x: 1'b0});
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        cyc();
        load_value = 27'd5;
        periodic   = 1'b0;
        load_valid = 1'b1;
        start      = 1'b1;
        cyc();
        load_valid = 1'b0;
        start      = 1'b0;
        n_checks++;
        if (count !== 27'd5 || busy !== 1'b0 || load_ready !== 1'b1) begin
            n_errors++;
            $display("FAIL load_with_start: count=%0d busy=%0b ready=%0b, required 5 0 1",
                     count, busy, load_ready);
        end
        cyc();
        n_checks++;
        if (busy !== 1'b0) begin
            n_errors++;
            $display("FAIL load_with_start_idle: busy=%0b, required 0", busy);
        end
    endtask

    task automatic test_stop();
        do_load(27'd10, 8'd0, 1'b0);
        do_start();
        for (int k = 1; k <= 4; k++) begin
            cyc();
            n_checks++;
            if (count !== 27'(10 - k)) begin
                n_errors++;
                $display("FAIL stop_run k=%0d: count=%0d, required %0d", k, count, 10 - k);
            end
        end
        exp_q.push_back('{d: 27'd6, x: 1'b0});
        stop = 1'b1;
        cyc();
        stop = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || count !== 27'd6 || expired !== 1'b0) begin
            n_errors++;
            $display("FAIL stop: busy=%0b count=%0d expired=%0b, required 0 6 0", busy, count, expired);
        end
        cyc();
        n_checks++;
        if (cap_en !== 1'b0 || count !== 27'd6) begin
            n_errors++;
            $display("FAIL stop_ack_once: cap_en=%0b count=%0d, required 0 6", cap_en, count);
        end
        start = 1'b1;
        stop  = 1'b1;
        cyc();
        start = 1'b0;
        stop  = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || count !== 27'd6) begin
            n_errors++;
            $display("FAIL stop_over_start: busy=%0b count=%0d, required 0 6", busy, count);
        end
    endtask

    task automatic test_zero_reload();
        do_load(27'd0, 8'd0, 1'b0);
        do_start();
        for (int k = 1; k <= 3; k++) begin
            n_checks++;
            if (busy !== 1'b0 || expired !== 1'b0 || count !== 27'd0) begin
                n_errors++;
                $display("FAIL zero_reload k=%0d: busy=%0b expired=%0b count=%0d, required 0 0 0",
                         k, busy, expired, count);
            end
            cyc();
        end
    endtask

    task automatic test_reset_mid_run();
        do_load(27'd50, 8'd0, 1'b0);
        do_start();
        cyc();
        cyc();
        #3 clr_n = 1'b0;
        #1;
        n_checks++;
        if (count !== 27'd0 || load_ready !== 1'b1 || busy !== 1'b0 ||
            expired !== 1'b0 || cap_en !== 1'b0 || cap_d !== 27'd0) begin
            n_errors++;
            $display("FAIL reset_mid_run: count=%0d ready=%0b busy=%0b expired=%0b cap_en=%0b cap_d=%0d, required 0 1 0 0 0 0",
                     count, load_ready, busy, expired, cap_en, cap_d);
        end
        cyc();
        cyc();
        clr_n = 1'b1;
        cyc();
        cyc();
        n_checks++;
        if (busy !== 1'b0 || count !== 27'd0) begin
            n_errors++;
            $display("FAIL after_reset: busy=%0b count=%0d, required 0 0", busy, count);
        end
    endtask

    initial begin
        test_reset();
        test_one_shot();
        test_periodic();
        test_handshake();
        test_stop();
        test_zero_reload();
        test_reset_mid_run();
        cyc();
        cyc();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain: %0d expected cap_en events never seen, required 0",
                     exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
